// File: rtl/headgen_pkg.sv
// Shared definitions for the tunnel header generator: management table
// selects, IPv4 word width and the 1's-complement adder.
package headgen_pkg;

    typedef enum logic [1:0] {
        SEL_MC  = 2'd0,
        SEL_L3  = 2'd1,
        SEL_CS  = 2'd2,
        SEL_RSV = 2'd3
    } mgmt_sel_e;

    localparam int IPV4_W = 16;

    // 16-bit add with end-around carry; the folded result cannot carry again.
    function automatic logic [IPV4_W-1:0] ones_add16(input logic [IPV4_W-1:0] a,
                                                     input logic [IPV4_W-1:0] b);
        logic [IPV4_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[IPV4_W-1:0] + {{(IPV4_W-1){1'b0}}, s[IPV4_W]};
    endfunction

endpackage

// File: rtl/hdr_tdp_ram.sv
// True dual-port table: port A is the enable-gated datapath read with a
// resettable output register, port B the read-first management port.
module hdr_tdp_ram #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_en_i,
    input  logic [AW-1:0] a_addr_i,
    output logic [DW-1:0] a_q_o,
    input  logic          b_we_i,
    input  logic          b_re_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic [DW-1:0] b_q_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (b_we_i) mem_q[b_addr_i] <= b_wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_en_i) a_q <= mem_q[a_addr_i];
            if (b_re_i) b_q <= mem_q[b_addr_i];
        end
    end

    assign a_q_o = a_q;
    assign b_q_o = b_q;

endmodule

// File: rtl/headgen_pipe_s1_v2.sv
// Stage 1 of the tunnel header generator: two-stage stall-all pipeline doing
// microcode / L3 length / checksum lookups plus total length and checksum.
module headgen_pipe_s1_v2
    import headgen_pkg::*;
#(
    parameter  int MC_DW   = 9,
    parameter  int MC_AW   = 13,
    parameter  int VLAN_AW = 4,
    localparam int MGMT_DW = (MC_DW > 16) ? MC_DW : 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MC_AW-1:0]   in_addr,
    input  logic [15:0]        in_body_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MC_DW-1:0]   out_mcode,
    output logic [15:0]        out_body_len,
    output logic [15:0]        out_l3_len,
    output logic [15:0]        out_tot_len,
    output logic               out_len_err,
    output logic [15:0]        out_chsum,
    input  logic [1:0]         mgmt_sel,
    input  logic [MC_AW-1:0]   mgmt_addr,
    input  logic [MGMT_DW-1:0] mgmt_wdata,
    input  logic               mgmt_we,
    input  logic               mgmt_re,
    output logic [MGMT_DW-1:0] mgmt_rdata,
    output logic               mgmt_rvalid
);
    logic                adv;
    logic                v1_q, v2_q;
    logic [15:0]         body1_q;
    logic [VLAN_AW-1:0]  vlan;
    logic [VLAN_AW-1:0]  mgmt_vlan;
    logic [MC_DW-1:0]    mc_qa, mc_qb;
    logic [15:0]         l3_qa, l3_qb, cs_qa, cs_qb;

    logic [MC_DW-1:0]    mcode_q;
    logic [15:0]         body2_q, l3_q, tot_q, chsum_q;
    logic                err_q;
    mgmt_sel_e           rsel_q;
    logic                rvalid_q;

    logic [16:0]         t_sum;
    logic [15:0]         tot_d, chsum_d;
    logic                err_d;

    // Whole pipe advances together; a full S2 only moves when downstream takes it.
    assign adv       = ~v2_q | out_ready;
    assign in_ready  = rst & adv;
    assign vlan      = in_addr[MC_AW-1 -: VLAN_AW];
    assign mgmt_vlan = mgmt_addr[VLAN_AW-1:0];

    hdr_tdp_ram #(.DW(MC_DW), .AW(MC_AW)) u_mc_ram (
        .clk(clk), .rst_n(rst),
        .a_en_i(adv), .a_addr_i(in_addr), .a_q_o(mc_qa),
        .b_we_i(mgmt_we && (mgmt_sel == SEL_MC)), .b_re_i(mgmt_re && (mgmt_sel == SEL_MC)),
        .b_addr_i(mgmt_addr), .b_wdata_i(mgmt_wdata[MC_DW-1:0]), .b_q_o(mc_qb)
    );

    hdr_tdp_ram #(.DW(16), .AW(VLAN_AW)) u_l3_ram (
        .clk(clk), .rst_n(rst),
        .a_en_i(adv), .a_addr_i(vlan), .a_q_o(l3_qa),
        .b_we_i(mgmt_we && (mgmt_sel == SEL_L3)), .b_re_i(mgmt_re && (mgmt_sel == SEL_L3)),
        .b_addr_i(mgmt_vlan), .b_wdata_i(mgmt_wdata[15:0]), .b_q_o(l3_qb)
    );

    hdr_tdp_ram #(.DW(16), .AW(VLAN_AW)) u_cs_ram (
        .clk(clk), .rst_n(rst),
        .a_en_i(adv), .a_addr_i(vlan), .a_q_o(cs_qa),
        .b_we_i(mgmt_we && (mgmt_sel == SEL_CS)), .b_re_i(mgmt_re && (mgmt_sel == SEL_CS)),
        .b_addr_i(mgmt_vlan), .b_wdata_i(mgmt_wdata[15:0]), .b_q_o(cs_qb)
    );

    // Table holds ~S, so un-invert, fold in the (possibly clamped) length, invert.
    always_comb begin
        t_sum   = {1'b0, l3_qa} + {1'b0, body1_q};
        err_d   = t_sum[16];
        tot_d   = err_d ? 16'hFFFF : t_sum[15:0];
        chsum_d = ~ones_add16(~cs_qa, tot_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            body1_q  <= '0;
            mcode_q  <= '0;
            body2_q  <= '0;
            l3_q     <= '0;
            tot_q    <= '0;
            err_q    <= 1'b0;
            chsum_q  <= '0;
            rsel_q   <= SEL_MC;
            rvalid_q <= 1'b0;
        end else begin
            if (adv) begin
                v1_q    <= in_valid & in_ready;
                body1_q <= in_body_len;
                v2_q    <= v1_q;
                mcode_q <= mc_qa;
                body2_q <= body1_q;
                l3_q    <= l3_qa;
                tot_q   <= tot_d;
                err_q   <= err_d;
                chsum_q <= chsum_d;
            end
            rvalid_q <= mgmt_re;
            if (mgmt_re) rsel_q <= mgmt_sel_e'(mgmt_sel);
        end
    end

    // Port B registers only update on their own read, so the mux output holds.
    always_comb begin
        mgmt_rdata = '0;
        case (rsel_q)
            SEL_MC:  mgmt_rdata = MGMT_DW'(mc_qb);
            SEL_L3:  mgmt_rdata = MGMT_DW'(l3_qb);
            SEL_CS:  mgmt_rdata = MGMT_DW'(cs_qb);
            default: mgmt_rdata = '0;
        endcase
    end

    assign mgmt_rvalid  = rvalid_q;
    assign out_valid    = v2_q;
    assign out_mcode    = mcode_q;
    assign out_body_len = body2_q;
    assign out_l3_len   = l3_q;
    assign out_tot_len  = tot_q;
    assign out_len_err  = err_q;
    assign out_chsum    = chsum_q;

endmodule
